// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The fetch queue stores {instruction, fetch PC} pairs as fetch_entry_t.
package fetch_pkg;

  localparam int ADDR_WIDTH  = 16;
  localparam int INSTR_WIDTH = 16;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } fetch_entry_t;

  localparam instr_t       NOP_INSTR   = 16'h0000;
  localparam fetch_entry_t EMPTY_ENTRY = '{instr: NOP_INSTR, pc: '0};

  // Sequential PC step; wraps silently at the top of the address space.
  function automatic addr_t nextPc(input addr_t pc);
    return pc + addr_t'(1);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: ROM address/data, branch redirect from execute and the
// instruction handshake towards decode.
interface instruction_fetch_if;
  import fetch_pkg::*;

  addr_t  InstructionAddress;
  instr_t InstructionIn;
  logic   RedirectValid;
  addr_t  RedirectAddress;
  logic   InstructionValid;
  logic   InstructionReady;
  instr_t Instruction;
  addr_t  InstructionPC;

  modport master (
    output InstructionAddress,
    input  InstructionIn,
    input  RedirectValid,
    input  RedirectAddress,
    output InstructionValid,
    input  InstructionReady,
    output Instruction,
    output InstructionPC
  );

  modport slave (
    input  InstructionAddress,
    output InstructionIn,
    output RedirectValid,
    output RedirectAddress,
    input  InstructionValid,
    output InstructionReady,
    input  Instruction,
    input  InstructionPC
  );

endinterface

// File: rtl/instruction_fetch_queue.sv
// Small power-of-two FIFO of fetch entries. Flush wins over push/pop so a
// redirect empties the queue in a single edge.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  fetch_entry_t       i_pushData,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [COUNT_W-1:0] o_count,
  output fetch_entry_t       o_head
);

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [COUNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= EMPTY_ENTRY;
      end
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wrPtr] <= i_pushData;
        r_wrPtr        <= r_wrPtr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + COUNT_W'(1);
        2'b01:   r_count <= r_count - COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An empty queue presents a NOP at PC 0 rather than a stale slot.
  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? r_mem[r_rdPtr] : EMPTY_ENTRY;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, feeds the ROM address and pushes ROM data into
// the fetch queue; a redirect flushes the queue and reloads the PC.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int    QUEUE_DEPTH = 2,
  parameter addr_t RESET_PC    = 16'h0001
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master fetchIf
);

  localparam int COUNT_W = $clog2(QUEUE_DEPTH + 1);

  addr_t              r_pc;
  logic [COUNT_W-1:0] w_count;
  fetch_entry_t       w_head;
  fetch_entry_t       w_newEntry;
  logic               w_valid;
  logic               w_full;
  logic               w_dequeue;
  logic               w_enqueue;

  assign w_valid    = (w_count != '0);
  assign w_full     = (w_count == COUNT_W'(QUEUE_DEPTH));
  assign w_dequeue  = w_valid & fetchIf.InstructionReady;
  // A full queue can still accept when decode frees the head this cycle.
  assign w_enqueue  = ~fetchIf.RedirectValid & (~w_full | w_dequeue);
  assign w_newEntry = '{instr: fetchIf.InstructionIn, pc: r_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (fetchIf.RedirectValid) begin
      r_pc <= fetchIf.RedirectAddress;
    end else if (w_enqueue) begin
      r_pc <= nextPc(r_pc);
    end
  end

  fetch_queue #(
    .DEPTH   (QUEUE_DEPTH),
    .COUNT_W (COUNT_W)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_enqueue),
    .i_pushData (w_newEntry),
    .i_pop      (w_dequeue),
    .i_flush    (fetchIf.RedirectValid),
    .o_count    (w_count),
    .o_head     (w_head)
  );

  assign fetchIf.InstructionAddress = r_pc;
  assign fetchIf.InstructionValid   = w_valid;
  assign fetchIf.Instruction        = w_head.instr;
  assign fetchIf.InstructionPC      = w_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: table-driven cycle vectors plus
// hand-written reset sequences, with a behavioural ROM holding the program.
module tb_instruction_fetch;
  import fetch_pkg::*;

  typedef struct {
    logic   ready;
    logic   redirValid;
    addr_t  redirAddr;
    logic   expValid;
    instr_t expInstr;
    addr_t  expPC;
    addr_t  expAddr;
  } vec_t;

  logic clk;
  logic rst_n;
  int   compareCount;
  int   mismatchCount;
  vec_t vecs[$];

  instruction_fetch_if ifc ();

  instruction_fetch #(
    .QUEUE_DEPTH (2),
    .RESET_PC    (16'h0001)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fetchIf (ifc.master)
  );

  // Free-running clock; rising edges at 5, 15, 25 ... so negedges are safe
  // points to sample outputs and change inputs.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational ROM: Fibonacci program start plus distinctive words at the
  // addresses the redirect and wrap tests visit.
  function automatic instr_t romData(input addr_t a);
    case (a)
      16'h0000: return 16'h1234;
      16'h0001: return 16'h0170;
      16'h0002: return 16'h0270;
      16'h0003: return 16'hC301;
      16'h0004: return 16'h4402;
      16'h0005: return 16'h3251;
      16'h0006: return 16'h3411;
      16'h0007: return 16'h5A07;
      16'hFFFF: return 16'h7FFE;
      default:  return 16'hDEAD;
    endcase
  endfunction

  assign ifc.InstructionIn = romData(ifc.InstructionAddress);

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkField(input string name, input logic [15:0] actual,
                            input logic [15:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expValid,
                             input instr_t expInstr, input addr_t expPC,
                             input addr_t expAddr);
    checkField({tag, ".valid"}, {15'd0, ifc.InstructionValid}, {15'd0, expValid});
    checkField({tag, ".instr"}, ifc.Instruction, expInstr);
    checkField({tag, ".pc"},    ifc.InstructionPC, expPC);
    checkField({tag, ".addr"},  ifc.InstructionAddress, expAddr);
  endtask

  task automatic applyStimulus(input logic ready, input logic redirValid,
                               input addr_t redirAddr);
    ifc.InstructionReady = ready;
    ifc.RedirectValid    = redirValid;
    ifc.RedirectAddress  = redirAddr;
  endtask

  task automatic addVec(input logic ready, input logic redirValid,
                        input addr_t redirAddr, input logic expValid,
                        input instr_t expInstr, input addr_t expPC,
                        input addr_t expAddr);
    vec_t v;
    v.ready      = ready;
    v.redirValid = redirValid;
    v.redirAddr  = redirAddr;
    v.expValid   = expValid;
    v.expInstr   = expInstr;
    v.expPC      = expPC;
    v.expAddr    = expAddr;
    vecs.push_back(v);
  endtask

  // Each vector: outputs expected during the cycle, inputs held for its edge.
  task automatic runTable(input string tag);
    foreach (vecs[i]) begin
      checkOutput($sformatf("%s[%0d]", tag, i), vecs[i].expValid,
                  vecs[i].expInstr, vecs[i].expPC, vecs[i].expAddr);
      applyStimulus(vecs[i].ready, vecs[i].redirValid, vecs[i].redirAddr);
      @(negedge clk);
    end
    vecs.delete();
  endtask

  // Asserts reset away from a clock edge, checks the asynchronous reset
  // values, then releases on a negedge so the next rising edge is cycle 0.
  task automatic doReset(input string tag);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, ".async"}, 1'b0, 16'h0000, 16'h0000, 16'h0001);
    @(negedge clk);
    checkOutput({tag, ".held"}, 1'b0, 16'h0000, 16'h0000, 16'h0001);
    rst_n = 1'b1;
  endtask

  // Main sequence.
  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst_n         = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    #2;
    doReset("rst0");

    // Ready held high straight out of reset: one instruction per cycle.
    addVec(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001);
    addVec(1, 0, 16'h0000, 1, 16'h0170, 16'h0001, 16'h0002);
    addVec(1, 0, 16'h0000, 1, 16'h0270, 16'h0002, 16'h0003);
    addVec(1, 0, 16'h0000, 1, 16'hC301, 16'h0003, 16'h0004);
    addVec(1, 0, 16'h0000, 1, 16'h4402, 16'h0004, 16'h0005);
    runTable("stream");

    doReset("rst1");

    // Backpressure fill, drain, redirect while full, redirect with dequeue
    // to 0xFFFF and the PC wrap to 0x0000.
    addVec(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0001);
    addVec(0, 0, 16'h0000, 1, 16'h0170, 16'h0001, 16'h0002);
    addVec(0, 0, 16'h0000, 1, 16'h0170, 16'h0001, 16'h0003);
    addVec(0, 0, 16'h0000, 1, 16'h0170, 16'h0001, 16'h0003);
    addVec(1, 0, 16'h0000, 1, 16'h0170, 16'h0001, 16'h0003);
    addVec(1, 0, 16'h0000, 1, 16'h0270, 16'h0002, 16'h0004);
    addVec(1, 0, 16'h0000, 1, 16'hC301, 16'h0003, 16'h0005);
    addVec(0, 0, 16'h0000, 1, 16'h4402, 16'h0004, 16'h0006);
    addVec(0, 1, 16'h0005, 1, 16'h4402, 16'h0004, 16'h0006);
    addVec(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0005);
    addVec(1, 0, 16'h0000, 1, 16'h3251, 16'h0005, 16'h0006);
    addVec(1, 0, 16'h0000, 1, 16'h3411, 16'h0006, 16'h0007);
    addVec(1, 1, 16'hFFFF, 1, 16'h5A07, 16'h0007, 16'h0008);
    addVec(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'hFFFF);
    addVec(1, 0, 16'h0000, 1, 16'h7FFE, 16'hFFFF, 16'h0000);
    addVec(1, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0001);
    addVec(1, 0, 16'h0000, 1, 16'h0170, 16'h0001, 16'h0002);
    runTable("bp");

    // Reset asserted mid-stream with a full queue, then a clean restart.
    doReset("rst2");
    applyStimulus(1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid.full", 1'b1, 16'h0170, 16'h0001, 16'h0003);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid.async", 1'b0, 16'h0000, 16'h0000, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid.release", 1'b0, 16'h0000, 16'h0000, 16'h0001);
    @(negedge clk);
    checkOutput("mid.restart", 1'b1, 16'h0170, 16'h0001, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage that drives the instruction ROM address and turns the ROM's combinational output into a buffered, handshaked instruction stream for decode. It holds the program counter, advances it sequentially, absorbs decode backpressure in a small queue, and services branch redirects from execute by flushing the queue and reloading the PC. It sits between the execute stage's branch resolution and the decode stage, with the instruction ROM hanging off its address/data pair.

## Interface
- ADDR_WIDTH, 16, PC and ROM address width
- INSTR_WIDTH, 16, instruction word width
- QUEUE_DEPTH, 2, fetch queue entries (power of two, >= 2)
- RESET_PC, 16'h0001, PC loaded on reset
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- InstructionAddress  out  ADDR_WIDTH  address to ROM, equals current PC
- InstructionIn  in  INSTR_WIDTH  ROM data for InstructionAddress, valid same cycle
- RedirectValid  in  1  branch taken, reload PC this cycle
- RedirectAddress  in  ADDR_WIDTH  branch target
- InstructionValid  out  1  queue head holds an instruction
- InstructionReady  in  1  decode accepts head this cycle
- Instruction  out  INSTR_WIDTH  queue head instruction
- InstructionPC  out  ADDR_WIDTH  address the head instruction was fetched from

## Operation
- State: PC register; queue of QUEUE_DEPTH {instr, pc} entries with read/write pointers and occupancy count (0..QUEUE_DEPTH).
- Dequeue = InstructionValid & InstructionReady.
- Enqueue = !RedirectValid & (count < QUEUE_DEPTH | Dequeue); writes {InstructionIn, PC} at tail, PC <= PC + 1.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF + 1 = 0x0000, no flag.
- Redirect (priority over everything): PC <= RedirectAddress, count <= 0, pointers reset, no enqueue; a dequeue in the same cycle still counts as accepted by decode (the head handshake completes), the rest of the queue is discarded.
- No enqueue stall other than full queue; ROM is assumed single-cycle combinational.
- InstructionValid = (count != 0). Instruction/InstructionPC = head entry; when empty they hold 0.
- Simultaneous enqueue and dequeue when full: both occur, count unchanged.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): PC = RESET_PC, count = 0, InstructionAddress = RESET_PC, InstructionValid = 0, Instruction = 0, InstructionPC = 0.
- First edge after reset release: entry for RESET_PC enqueued; InstructionValid = 1 one cycle after release.
- Steady state with InstructionReady held high: one instruction per cycle, PC of consecutive outputs increments by 1.
- Redirect at cycle N: InstructionValid = 0 in cycle N+1; target instruction at head with InstructionValid = 1 in cycle N+2 (one bubble pair).
- Backpressure: with Ready low, queue fills in QUEUE_DEPTH cycles, then PC and InstructionAddress freeze until a dequeue.
- Reset mid-operation: all queued entries discarded immediately, outputs go to reset values asynchronously.

## Structure
- Package fetch_pkg: ADDR_WIDTH/INSTR_WIDTH constants, instr_t and addr_t typedefs, fetch_entry_t struct {instr, pc}, NOP encoding 16'h0000.
- Sub-module fetch_queue: parameterised FIFO of fetch_entry_t with push, pop, flush, count, head outputs; instruction_fetch holds PC and enqueue/redirect control only.

## Test plan
- Reset release, Ready high, ROM loaded with the Fibonacci program -> outputs 0x0170@0x0001, 0x0270@0x0002, 0xC301@0x0003 on consecutive cycles.
- Ready low 4 cycles after reset -> count saturates at 2, InstructionAddress holds 0x0003, Ready high then yields 0x0001, 0x0002, 0x0003 with no loss or duplication.
- Redirect to 0x0005 while queue full -> next valid output two cycles later is 0x3251@0x0005, followed by 0x3411@0x0006; stale entries never appear.
- Redirect to 0xFFFF, Ready high -> outputs PC 0xFFFF then 0x0000 (wrap, no error).
- Redirect coincident with Dequeue -> current head consumed once, next valid is the target entry.
- rst_n asserted mid-stream with count = 2 -> InstructionValid drops immediately, after release fetch restarts at 0x0001.
